crc32_frame_checker: RTL and testbench



---
 rtl/crc32_frame_checker_pkg.sv | 18 +
 rtl/crc32_frame_checker_if.sv | 13 +
 rtl/bit_reverser.sv | 19 +
 rtl/crc32_trailer_buffer.sv | 42 ++++
 rtl/crc32_frame_checker.sv | 139 +++++++++++++
 tb/tb_crc32_frame_checker.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/crc32_frame_checker_pkg.sv
// Shared constants for the CRC32 frame checker: FSM encoding, init/xor masks
// and the trailer length.
package crc32_frame_checker_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [31:0] CRC_INIT_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] XOR_OUT_MASK  = 32'hFFFF_FFFF;

  localparam int unsigned TRAILER_LEN = 4;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/crc32_frame_checker_if.sv
// Byte stream into the CRC32 frame checker; s_last marks the final trailer byte.
interface crc32_frame_checker_if;
  import crc32_frame_checker_pkg::*;

  logic  s_valid;
  logic  s_ready;
  byte_t s_data;
  logic  s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/bit_reverser.sv
// Optional bit-order reversal of a word; passes the value through when en = 0.
module bit_reverser #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = value[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/crc32_trailer_buffer.sv
// Four-byte delay line that holds back the trailer; hold[0] is the oldest byte.
module crc32_trailer_buffer
  import crc32_frame_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  byte_t       data,
  input  logic        lsb_first,
  output byte_t       oldest,
  output logic        full,
  output logic [31:0] trailer
);

  byte_t      hold [TRAILER_LEN];
  logic [2:0] count;

  // Push always shifts toward hold[0]; once full, the byte shifted out is the pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < TRAILER_LEN; i++) begin
        hold[i] <= '0;
      end
      count <= '0;
    end else if (push) begin
      for (int i = 0; i < TRAILER_LEN - 1; i++) begin
        hold[i] <= hold[i+1];
      end
      hold[TRAILER_LEN-1] <= data;
      if (!full) begin
        count <= count + 3'd1;
      end
    end
  end

  assign full    = (count == 3'(TRAILER_LEN));
  assign oldest  = hold[0];
  assign trailer = lsb_first ? {hold[3], hold[2], hold[1], hold[0]}
                             : {hold[0], hold[1], hold[2], hold[3]};

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC32 checker: bit-serial CRC over the payload, trailer compared at end of frame.
module crc32_frame_checker
  import crc32_frame_checker_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_ref_in,
  input  logic                         cfg_xor_out,
  input  logic                         cfg_init,
  input  logic [31:0]                  cfg_poly,
  crc32_frame_checker_if.slave         stream,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         crc_ok,
  output logic                         crc_err,
  output logic                         short_err,
  output logic [31:0]                  crc_calc,
  output logic [31:0]                  crc_rx
);

  logic [2:0]  state;
  logic [2:0]  shift_cnt;
  logic        pending_last;
  logic [31:0] crc;
  logic [31:0] poly;
  logic [31:0] init_value;
  logic [31:0] crc_stepped;
  logic [31:0] calc_value;
  logic [31:0] trailer;
  byte_t       oldest;
  logic        buf_full;
  logic        accept;
  logic        pop;

  bit_reverser #(.WIDTH(32)) u_poly_rev (
    .en     (cfg_ref_in),
    .value  (cfg_poly),
    .result (poly)
  );

  crc32_trailer_buffer u_trailer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == ST_DONE),
    .push      (accept),
    .data      (stream.s_data),
    .lsb_first (cfg_ref_in),
    .oldest    (oldest),
    .full      (buf_full),
    .trailer   (trailer)
  );

  assign stream.s_ready = (state == ST_IDLE) || (state == ST_ACCEPT);
  assign accept         = stream.s_valid && stream.s_ready;
  assign pop            = accept && buf_full;
  assign busy           = (state == ST_ACCEPT) || (state == ST_SHIFT) || (state == ST_CHECK);
  assign frame_done     = (state == ST_DONE);
  assign init_value     = cfg_init ? CRC_INIT_ONES : 32'h0;
  assign calc_value     = crc ^ (cfg_xor_out ? XOR_OUT_MASK : 32'h0);

  always_comb begin
    if (cfg_ref_in) begin
      crc_stepped = crc[0] ? ((crc >> 1) ^ poly) : (crc >> 1);
    end else begin
      crc_stepped = crc[31] ? ((crc << 1) ^ poly) : (crc << 1);
    end
  end

  // A popped byte costs 8 SHIFT cycles; s_last on it is remembered until they finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shift_cnt    <= '0;
      pending_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCEPT: begin
          if (accept) begin
            if (buf_full) begin
              state        <= ST_SHIFT;
              pending_last <= stream.s_last;
            end else begin
              state <= stream.s_last ? ST_CHECK : ST_ACCEPT;
            end
          end
        end
        ST_SHIFT: begin
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) begin
            state <= pending_last ? ST_CHECK : ST_ACCEPT;
          end
        end
        ST_CHECK: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= init_value;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: crc <= init_value;
        ST_ACCEPT: begin
          if (pop) begin
            crc <= crc ^ (cfg_ref_in ? {24'h0, oldest} : {oldest, 24'h0});
          end
        end
        ST_SHIFT: crc <= crc_stepped;
        default:  crc <= crc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      short_err <= 1'b0;
      crc_calc  <= '0;
      crc_rx    <= '0;
    end else if (state == ST_CHECK) begin
      crc_calc <= calc_value;
      crc_rx   <= trailer;
      if (!buf_full) begin
        short_err <= 1'b1;
        crc_err   <= 1'b1;
        crc_ok    <= 1'b0;
      end else begin
        short_err <= 1'b0;
        crc_ok    <= (calc_value == trailer);
        crc_err   <= (calc_value != trailer);
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker: directed CRC vectors plus random frames
// against a bitwise polynomial-division reference model.
module tb_crc32_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_ref_in, cfg_xor_out, cfg_init;
  logic [31:0] cfg_poly;
  logic        busy, frame_done, crc_ok, crc_err, short_err;
  logic [31:0] crc_calc, crc_rx;

  crc32_frame_checker_if bus ();

  crc32_frame_checker dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_ref_in  (cfg_ref_in),
    .cfg_xor_out (cfg_xor_out),
    .cfg_init    (cfg_init),
    .cfg_poly    (cfg_poly),
    .stream      (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .short_err   (short_err),
    .crc_calc    (crc_calc),
    .crc_rx      (crc_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    bit          ok;
    bit          err;
    bit          shrt;
    logic [31:0] calc;
    logic [31:0] rx;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] frame[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Rocksoft-style model: MSB-first polynomial division, reflected variants via mirrored I/O.
  function automatic logic [31:0] model_crc(input logic [7:0] data[$], input bit reflected,
                                            input bit init_ones, input logic [31:0] poly);
    logic [31:0] r;
    logic [7:0]  b;
    logic        top;
    r = init_ones ? 32'hFFFF_FFFF : 32'h0;
    foreach (data[k]) begin
      b = reflected ? reflect8(data[k]) : data[k];
      for (int j = 7; j >= 0; j--) begin
        top = r[31] ^ b[j];
        r   = {r[30:0], 1'b0} ^ (top ? poly : 32'h0);
      end
    end
    return reflected ? reflect32(r) : r;
  endfunction

  function automatic exp_t model_frame(input logic [7:0] bytes[$], input int done_cyc);
    exp_t       e;
    logic [7:0] payload[$];
    int         n;
    n = bytes.size();
    for (int k = 0; k < n - 4; k++) payload.push_back(bytes[k]);
    e.done_cyc = done_cyc;
    e.shrt     = (n < 4);
    e.calc     = model_crc(payload, cfg_ref_in, cfg_init, cfg_poly)
                 ^ (cfg_xor_out ? 32'hFFFF_FFFF : 32'h0);
    e.rx       = 32'h0;
    if (n >= 4) begin
      e.rx = cfg_ref_in ? {bytes[n-1], bytes[n-2], bytes[n-3], bytes[n-4]}
                        : {bytes[n-4], bytes[n-3], bytes[n-2], bytes[n-1]};
    end
    e.ok  = !e.shrt && (e.calc == e.rx);
    e.err = !e.ok;
    return e;
  endfunction

  task automatic set_cfg(input bit ref_in, input bit init_ones, input bit xor_out, input logic [31:0] poly);
    cfg_ref_in  = ref_in;
    cfg_init    = init_ones;
    cfg_xor_out = xor_out;
    cfg_poly    = poly;
  endtask

  // Drives one frame; after each non-final byte the s_ready low run must match the payload timing.
  task automatic applyStimulus(input logic [7:0] bytes[$], input bit has_last, input int max_gap);
    int n, waited, lows, gap;
    n = bytes.size();
    bus.s_valid = 1'b1;
    bus.s_data  = bytes[0];
    bus.s_last  = has_last && (n == 1);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = bytes[i];
      bus.s_last  = has_last && (i == n - 1);
      waited = 0;
      while (!bus.s_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) checkOutput("ready_timeout", 32'd1, 32'd0);
      if (has_last && i == n - 1) exp_q.push_back(model_frame(bytes, cyc + ((n > 4) ? 10 : 2)));
      @(negedge clk);
      if (i == n - 1) break;
      bus.s_data = bytes[i+1];
      bus.s_last = has_last && (i + 1 == n - 1);
      lows = 0;
      while (!bus.s_ready && lows < 20) begin
        @(negedge clk);
        lows++;
      end
      checkOutput($sformatf("ready_low_after_byte%0d", i), 32'(lows), (i >= 4) ? 32'd8 : 32'd0);
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      if (gap > 0) begin
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_crc_ok"}, 32'(crc_ok), 32'd0);
    checkOutput({tag, "_crc_err"}, 32'(crc_err), 32'd0);
    checkOutput({tag, "_short_err"}, 32'(short_err), 32'd0);
    checkOutput({tag, "_crc_calc"}, crc_calc, 32'd0);
    checkOutput({tag, "_crc_rx"}, crc_rx, 32'd0);
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
        checkOutput("crc_ok", 32'(crc_ok), 32'(e.ok));
        checkOutput("crc_err", 32'(crc_err), 32'(e.err));
        checkOutput("short_err", 32'(short_err), 32'(e.shrt));
        checkOutput("crc_calc", crc_calc, e.calc);
        if (!e.shrt) checkOutput("crc_rx", crc_rx, e.rx);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] payload[$];
    logic [31:0] c;
    logic [7:0] tb[4];
    int plen;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    set_cfg(1, 1, 1, 32'h04C11DB7);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    frame = payload;
    frame.push_back(8'h26); frame.push_back(8'h39); frame.push_back(8'hF4); frame.push_back(8'hCB);
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("crc32_calc", crc_calc, 32'hCBF43926);
    checkOutput("crc32_rx", crc_rx, 32'hCBF43926);
    checkOutput("crc32_ok", 32'(crc_ok), 32'd1);

    set_cfg(0, 1, 1, 32'h04C11DB7);
    frame = payload;
    frame.push_back(8'hFC); frame.push_back(8'h89); frame.push_back(8'h19); frame.push_back(8'h18);
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("bzip2_calc", crc_calc, 32'hFC891918);
    checkOutput("bzip2_ok", 32'(crc_ok), 32'd1);

    set_cfg(0, 1, 0, 32'h04C11DB7);
    frame = payload;
    frame.push_back(8'h03); frame.push_back(8'h76); frame.push_back(8'hE6); frame.push_back(8'hE8);
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("mpeg2_err", 32'(crc_err), 32'd1);
    checkOutput("mpeg2_calc", crc_calc, 32'h0376E6E7);
    checkOutput("mpeg2_rx", crc_rx, 32'h0376E6E8);

    set_cfg(1, 1, 1, 32'h04C11DB7);
    frame = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("empty_ok", 32'(crc_ok), 32'd1);

    frame = '{8'hAA, 8'hBB, 8'hCC};
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("short3_short_err", 32'(short_err), 32'd1);
    checkOutput("short3_crc_err", 32'(crc_err), 32'd1);

    frame = payload;
    frame.push_back(8'h26); frame.push_back(8'h39); frame.push_back(8'hF4); frame.push_back(8'hCB);
    applyStimulus(frame, 1, 0);
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("b2b_ok", 32'(crc_ok), 32'd1);

    frame = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(frame, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midshift_reset");
    repeat (12) @(negedge clk);
    frame = payload;
    frame.push_back(8'h26); frame.push_back(8'h39); frame.push_back(8'hF4); frame.push_back(8'hCB);
    applyStimulus(frame, 1, 0);
    drain();
    checkOutput("post_reset_ok", 32'(crc_ok), 32'd1);

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(2, 0))
        0:       c = 32'h04C11DB7;
        1:       c = 32'h1EDC6F41;
        default: c = $urandom | 32'h1;
      endcase
      set_cfg($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0), c);
      frame.delete();
      if ($urandom_range(7, 0) == 0) begin
        plen = $urandom_range(3, 1);
        for (int k = 0; k < plen; k++) frame.push_back(8'($urandom));
      end else begin
        plen = $urandom_range(10, 0);
        for (int k = 0; k < plen; k++) frame.push_back(8'($urandom));
        c = model_crc(frame, cfg_ref_in, cfg_init, cfg_poly) ^ (cfg_xor_out ? 32'hFFFF_FFFF : 32'h0);
        if ($urandom_range(1, 0) == 1) c = c ^ (32'h1 << $urandom_range(31, 0));
        for (int k = 0; k < 4; k++) tb[k] = cfg_ref_in ? c[8*k +: 8] : c[8*(3-k) +: 8];
        for (int k = 0; k < 4; k++) frame.push_back(tb[k]);
      end
      applyStimulus(frame, 1, 3);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
